// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: request/acknowledge front end for the single-port
// synchronous RAM. It latches one request at a time and sequences the RAM's
// registered read latency and optional wait states. It returns a one-cycle
// ack, with registered read data for reads.
module mem_access_ctrl #(
  parameter int WIDTH       = 8,
  parameter int ADDR_SIZE   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic                 ack,
  output logic [WIDTH-1:0]     rdata,
  output logic                 busy,
  output logic                 m_cs,
  output logic                 m_wen,
  output logic [ADDR_SIZE-1:0] m_ra,
  output logic [WIDTH-1:0]     m_din,
  input  logic [WIDTH-1:0]     m_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DATA   = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t                 state;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic                   we_q;
  logic [WIDTH-1:0]       wdata_q;
  logic [3:0]             wait_cnt;

  // Transaction sequencer; ack is set on the edge that enters ACK, so it is
  // high for exactly the ACK cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ack      <= 1'b0;
      rdata    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            addr_q   <= addr;
            we_q     <= we;
            wdata_q  <= wdata;
            wait_cnt <= WAIT_INIT;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else if (we_q) begin
            ack   <= 1'b1;
            state <= ACK;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          rdata <= m_dout;
          ack   <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ack   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM pin decode; chip select is gated by reset so an ACCESS cycle that
  // coincides with reset never reaches the RAM.
  always_comb begin
    busy  = (state != IDLE);
    m_cs  = (state == ACCESS) && reset;
    m_wen = (state == ACCESS) && we_q;
    m_ra  = addr_q;
    m_din = wdata_q;
  end

endmodule
